// File: rtl/muldiv_alu.sv
// Integer ALU: single-cycle logic/shift/add ops plus iterative shift-add multiply
// and restoring divide. Define ALU_DIV_EN to build the divider (codes 24/25).
module muldiv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] s_1,
  input  logic [WIDTH-1:0] s_2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int SH = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic             hi_sel;
  logic [WIDTH-1:0] opb_q, acc_q, lo_q;

  // single-cycle datapath
  logic [SH-1:0]      amt;
  logic [2*WIDTH-1:0] lsl_w, lsr_w;
  logic [WIDTH-1:0]   add_b, sc_res;
  logic               add_ci, sub_op, ovf, sc_c, sc_o, sc_sup, start_mul, start_div;
  logic [WIDTH:0]     sum;

  always_comb begin
    amt    = s_2[SH-1:0];
    lsl_w  = {{WIDTH{1'b0}}, s_1} << amt;
    lsr_w  = {s_1, {WIDTH{1'b0}}} >> amt;
    sub_op = (alu_op == 5'd16) || (alu_op == 5'd17);
    add_b  = sub_op ? ~s_2 : s_2;
    add_ci = (alu_op == 5'd16) ? 1'b1 : (alu_op == 5'd14) ? 1'b0 : flags[0];
    sum    = {1'b0, s_1} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    ovf    = (s_1[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != s_1[WIDTH-1]);
    sc_res    = '0;
    sc_c      = 1'b0;
    sc_o      = 1'b0;
    sc_sup    = 1'b1;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (alu_op)
      5'd0:  sc_res = s_1 & s_2;
      5'd1:  sc_res = ~(s_1 & s_2);
      5'd2:  sc_res = s_1 | s_2;
      5'd3:  sc_res = ~(s_1 | s_2);
      5'd4:  sc_res = s_1 ^ s_2;
      5'd5:  sc_res = ~(s_1 ^ s_2);
      5'd6:  sc_res = ~s_2;
      // bit WIDTH of lsl_w / bit WIDTH-1 of lsr_w hold the last bit out, 0 at amt 0
      5'd7:  begin sc_res = lsl_w[WIDTH-1:0];                      sc_c = lsl_w[WIDTH];   end
      5'd8:  begin sc_res = lsr_w[2*WIDTH-1:WIDTH];                sc_c = lsr_w[WIDTH-1]; end
      5'd9:  begin sc_res = WIDTH'($signed(s_1) >>> amt);          sc_c = lsr_w[WIDTH-1]; end
      5'd10: begin sc_res = lsl_w[WIDTH-1:0] | lsl_w[2*WIDTH-1:WIDTH]; sc_c = lsl_w[WIDTH]; end
      5'd11: begin sc_res = lsr_w[2*WIDTH-1:WIDTH] | lsr_w[WIDTH-1:0]; sc_c = lsr_w[WIDTH-1]; end
      5'd14, 5'd15, 5'd16, 5'd17: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_o   = ovf;
      end
      5'd22, 5'd23: start_mul = 1'b1;
`ifdef ALU_DIV_EN
      5'd24, 5'd25: start_div = 1'b1;
`endif
      default: sc_sup = 1'b0;
    endcase
  end

  // iterative datapath: acc_q is the high half (mul) or partial remainder (div)
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo, fin_res;
  logic             fin_c;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    fin_res = hi_sel ? step_hi : step_lo;
    fin_c   = hi_sel ? 1'b0 : (step_hi != '0);
`ifdef ALU_DIV_EN
    rem_sh   = {acc_q, lo_q[WIDTH-1]};
    div_ge   = rem_sh >= {1'b0, opb_q};
    div_diff = rem_sh[WIDTH-1:0] - opb_q;
    if (state == DIV) begin
      step_hi = div_ge ? div_diff : rem_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
      fin_res = hi_sel ? step_hi : step_lo;
      // a zero divisor naturally yields all-ones quotient and remainder = dividend
      fin_c   = (opb_q == '0);
    end
`endif
  end

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) begin
        if (start_mul)      state_nx = MUL;
        else if (start_div) state_nx = DIV;
      end
      MUL, DIV: if (cnt == CW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
      cnt       <= '0;
      hi_sel    <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          if (start_mul || start_div) begin
            acc_q  <= '0;
            lo_q   <= s_1;
            opb_q  <= s_2;
            hi_sel <= alu_op[0];
            cnt    <= CW'(WIDTH);
          end else begin
            out_valid <= 1'b1;
            result    <= sc_res;
            if (sc_sup) flags <= {sc_o, sc_res[WIDTH-1], sc_res == '0, sc_c};
          end
        end
      end else begin
        acc_q <= step_hi;
        lo_q  <= step_lo;
        cnt   <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          out_valid <= 1'b1;
          result    <= fin_res;
          flags     <= {1'b0, fin_res[WIDTH-1], fin_res == '0, fin_c};
        end
      end
    end
  end
endmodule
